// File: rtl/jt10_adpcm_div.sv
`default_nettype none
// ============================================================================
// Module      : jt10_adpcm_div
// Description : Unsigned restoring shift-subtract divider. Produces one
//               quotient bit per enabled cycle, MSB first, and registers
//               d = a / b and r = a mod b on the final step.
//               Optional build macro JT10_ADPCM_DIV_DONE_EN adds a one-cycle
//               'done' pulse output that marks the d/r update.
// Revision    : 1.0 - initial release
// ============================================================================
module jt10_adpcm_div #(
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          start,
  input  logic [dw-1:0] a,
  input  logic [dw-1:0] b,
  output logic [dw-1:0] d,
  output logic [dw-1:0] r
`ifdef JT10_ADPCM_DIV_DONE_EN
  ,
  output logic          done
`endif
);

  // Step counter must be able to hold the value dw itself.
  localparam int CW = $clog2(dw + 1);
  localparam logic [CW-1:0] C_CNT_LOAD = CW'(dw);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(1);

  // Dividend shift register; quotient bits enter at the LSB as dividend bits
  // leave from the MSB, so after dw steps it holds the quotient.
  logic [dw-1:0] dividend_q, dividend_d;
  logic [dw-1:0] divisor_q,  divisor_d;
  // Partial remainder, one bit wider than the operands.
  logic [dw:0]   rem_q,      rem_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [dw-1:0] d_q,        d_d;
  logic [dw-1:0] r_q,        r_d;

  // Datapath for a single restoring step.
  logic [dw:0]   w_shifted;
  logic [dw:0]   w_diff;
  logic          w_ge;
  logic [dw:0]   w_step_rem;
  logic [dw-1:0] w_step_quo;
  logic          w_busy;
  logic          w_last;

  // One shift-subtract step: the bit shifted out of the partial remainder
  // (rem_q[dw]) also forces a subtraction, keeping the compare exact.
  always_comb begin
    w_shifted  = {rem_q[dw-1:0], dividend_q[dw-1]};
    w_diff     = w_shifted - {1'b0, divisor_q};
    w_ge       = rem_q[dw] | (w_shifted >= {1'b0, divisor_q});
    w_step_rem = w_ge ? w_diff : w_shifted;
    w_step_quo = {dividend_q[dw-2:0], w_ge};
    w_busy     = (cnt_q != '0);
    w_last     = (cnt_q == C_CNT_LAST);
  end

  // Next-state selection: load on start, step while busy, publish on last step.
  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    d_d        = d_q;
    r_d        = r_q;
    if (cen) begin
      if (start) begin
        // (Re)load operands; any division in flight is abandoned and the
        // previous result stays visible.
        dividend_d = a;
        divisor_d  = b;
        rem_d      = '0;
        cnt_d      = C_CNT_LOAD;
      end else if (w_busy) begin
        dividend_d = w_step_quo;
        rem_d      = w_step_rem;
        cnt_d      = cnt_q - C_CNT_LAST;
        if (w_last) begin
          d_d = w_step_quo;
          r_d = w_step_rem[dw-1:0];
        end
      end
    end
  end

  // Architectural state; reset returns the block to idle with a zero result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      d_q        <= '0;
      r_q        <= '0;
    end else begin
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      d_q        <= d_d;
      r_q        <= r_d;
    end
  end

  assign d = d_q;
  assign r = r_q;

`ifdef JT10_ADPCM_DIV_DONE_EN
  logic done_q, done_d;

  // Pulse is asserted exactly on the edge that updates d/r.
  always_comb begin
    done_d = cen & ~start & w_last;
  end

  // Updated on every clk edge (not gated by cen) so it lasts one clk cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jt10_adpcm_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_jt10_adpcm_div
// Description : Directed self-checking bench for jt10_adpcm_div (dw = 16).
//               Also checks the done pulse when JT10_ADPCM_DIV_DONE_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jt10_adpcm_div;

  logic        clk;
  logic        rst;
  logic        cen;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] d;
  logic [15:0] r;
`ifdef JT10_ADPCM_DIV_DONE_EN
  logic        done;
`endif

  int n_checks;
  int n_fails;
  int done_cnt;
  logic [15:0] prev_d;
  logic [15:0] prev_r;

  jt10_adpcm_div #(.dw(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .start (start),
    .a     (a),
    .b     (b),
    .d     (d),
    .r     (r)
`ifdef JT10_ADPCM_DIV_DONE_EN
    ,
    .done  (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
`ifdef JT10_ADPCM_DIV_DONE_EN
    if (done === 1'b1) done_cnt++;
`endif
  endtask

  // Start held for two cycles, then released while a/b are scrambled.
  task automatic run_div(input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] ed, input logic [15:0] er, input string tag);
    done_cnt = 0;
    a = av; b = bv; start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    for (int k = 0; k < 15; k++) tick();
    check({tag, "_hold_d"}, 32'(d), 32'(prev_d));
    check({tag, "_hold_r"}, 32'(r), 32'(prev_r));
    tick();
    check({tag, "_d"}, 32'(d), 32'(ed));
    check({tag, "_r"}, 32'(r), 32'(er));
    tick();
    tick();
    check({tag, "_idle_d"}, 32'(d), 32'(ed));
`ifdef JT10_ADPCM_DIV_DONE_EN
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
`endif
    prev_d = ed;
    prev_r = er;
  endtask

  logic [15:0] va [9];
  logic [15:0] vb [9];
  logic [15:0] vd [9];
  logic [15:0] vr [9];

  initial begin
    n_checks = 0; n_fails = 0; done_cnt = 0;
    rst = 1'b1; cen = 1'b1; start = 1'b0; a = '0; b = '0;
    prev_d = '0; prev_r = '0;

    va[0] = 16'd1235;  vb[0] = 16'd23;    vd[0] = 16'd53;     vr[0] = 16'd16;
    va[1] = 16'd3235;  vb[1] = 16'd123;   vd[1] = 16'd26;     vr[1] = 16'd37;
    va[2] = 16'd32767; vb[2] = 16'd1;     vd[2] = 16'd32767;  vr[2] = 16'd0;
    va[3] = 16'd100;   vb[3] = 16'd1000;  vd[3] = 16'd0;      vr[3] = 16'd100;
    va[4] = 16'd28000; vb[4] = 16'd14000; vd[4] = 16'd2;      vr[4] = 16'd0;
    va[5] = 16'd500;   vb[5] = 16'd0;     vd[5] = 16'hFFFF;   vr[5] = 16'd500;
    va[6] = 16'hFFFF;  vb[6] = 16'hFFFF;  vd[6] = 16'd1;      vr[6] = 16'd0;
    va[7] = 16'hFFFF;  vb[7] = 16'd2;     vd[7] = 16'd32767;  vr[7] = 16'd1;
    va[8] = 16'd40000; vb[8] = 16'd3;     vd[8] = 16'd13333;  vr[8] = 16'd1;

    // Reset state.
    #12;
    check("reset_d", 32'(d), 32'd0);
    check("reset_r", 32'(r), 32'd0);
`ifdef JT10_ADPCM_DIV_DONE_EN
    check("reset_done", 32'(done), 32'd0);
`endif
    rst = 1'b0;
    tick();
    tick();
    check("idle_after_reset_d", 32'(d), 32'd0);

    // Directed divisions.
    for (int i = 0; i < 9; i++) run_div(va[i], vb[i], vd[i], vr[i], $sformatf("div%0d", i));

    // Abort: restart mid-division with new operands.
    done_cnt = 0;
    a = 16'd1235; b = 16'd23; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    a = 16'd3235; b = 16'd123; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    check("abort_hold_d", 32'(d), 32'(prev_d));
    check("abort_hold_r", 32'(r), 32'(prev_r));
    tick();
    check("abort_d", 32'(d), 32'd26);
    check("abort_r", 32'(r), 32'd37);
`ifdef JT10_ADPCM_DIV_DONE_EN
    check("abort_done_cnt", 32'(done_cnt), 32'd1);
`endif
    prev_d = 16'd26; prev_r = 16'd37;

    // Clock enable toggling: 16 enabled edges spread over 32 clocks.
    a = 16'd1235; b = 16'd23; start = 1'b1; cen = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cen = (i % 2 == 1);
      tick();
    end
    check("cen_hold_d", 32'(d), 32'(prev_d));
    check("cen_hold_r", 32'(r), 32'(prev_r));
    cen = 1'b0; tick();
    check("cen_frozen_d", 32'(d), 32'(prev_d));
    cen = 1'b1; tick();
    check("cen_d", 32'(d), 32'd53);
    check("cen_r", 32'(r), 32'd16);
    prev_d = 16'd53; prev_r = 16'd16;

    // Asynchronous reset mid-division; no result afterwards without start.
    done_cnt = 0;
    a = 16'd3235; b = 16'd123; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #3 rst = 1'b1;
    #1;
    check("rst_mid_d", 32'(d), 32'd0);
    check("rst_mid_r", 32'(r), 32'd0);
    #2 rst = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("rst_after_d", 32'(d), 32'd0);
    check("rst_after_r", 32'(r), 32'd0);
`ifdef JT10_ADPCM_DIV_DONE_EN
    check("rst_after_done_cnt", 32'(done_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jt10_adpcm_div.md
JT10_ADPCM_DIV -- requirements
Module: jt10_adpcm_div

Interface
REQ-001 Parameter: dw, default 16, operand/result width in bits (dw >= 2).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cen  input  1  clock enable; state advances only on clk edges where cen=1.
REQ-005 start  input  1  level request; loads operands and (re)starts a division.
REQ-006 a  input  dw  unsigned dividend.
REQ-007 b  input  dw  unsigned divisor.
REQ-008 d  output  dw  unsigned quotient, registered.
REQ-009 r  output  dw  unsigned remainder, registered.

Function
REQ-010 The block SHALL compute d = a / b and r = a mod b (unsigned), so that b*d + r == a and r < b whenever b != 0.
REQ-011 Algorithm: restoring shift-subtract, one quotient bit per enabled cycle, MSB first; the internal partial remainder is dw+1 bits wide so the compare/subtract never overflows.
REQ-012 On an enabled edge with start=1: latch a into a dividend shift register, latch b into a divisor register, clear the partial remainder, set the step counter to dw; d and r unchanged.
REQ-013 While start stays 1, every enabled edge SHALL reload from current a and b (last value before start falls is used).
REQ-014 On an enabled edge with start=0 and counter>0: shift {partial remainder, dividend MSB} left by one; if the result >= divisor, subtract the divisor and shift 1 into the quotient, else shift 0; decrement the counter.
REQ-015 On the enabled edge where the counter goes 1->0, d and r SHALL be updated with the final quotient and remainder on that same edge (latency: exactly dw enabled edges after the first enabled edge with start=0).
REQ-016 With counter=0 and start=0 the block SHALL be idle; d and r hold their last values indefinitely.
REQ-017 start asserted mid-division SHALL abort the operation and restart per REQ-012; d and r keep the previous result.
REQ-018 cen=0 SHALL freeze all state, including the counter, regardless of start.
REQ-019 Changing a or b while start=0 SHALL NOT affect a division in progress.
REQ-020 b=0: the algorithm runs unmodified, yielding d = all ones and r = a.

Reset
REQ-021 rst=1 SHALL asynchronously clear d, r, the partial remainder, the shift registers and the counter (idle state).
REQ-022 Reset asserted mid-division SHALL abort it; no result is produced after release until a new start.

Configuration
REQ-023 Macro JT10_ADPCM_DIV_DONE_EN: when defined, an extra output port done (1 bit) SHALL be present, reset to 0, pulsing high for exactly one clk cycle on the edge where d/r are updated (REQ-015), otherwise 0; when undefined, the port does not exist and behaviour is otherwise identical.

Verification
REQ-024 a=1235, b=23, start high 2 cycles then low; after 16 cycles -> d=53, r=16.
REQ-025 a=3235, b=123 -> d=26, r=37; a=32767, b=1 -> d=32767, r=0.
REQ-026 a=100, b=1000 -> d=0, r=100; a=28000, b=14000 -> d=2, r=0.
REQ-027 a=500, b=0 -> d=16'hFFFF, r=500; with JT10_ADPCM_DIV_DONE_EN, done pulses once per division.
REQ-028 Start 1235/23, reassert start with a=3235, b=123 after 5 cycles -> d/r keep prior value until 16 cycles after second start falls, then d=26, r=37; cen toggling 1/0 doubles latency with identical results.
REQ-029 Assert rst mid-division -> d=0, r=0 immediately, no later update without a new start.
